// File: rtl/noc_vc_pkg.sv
// rtl/noc_vc_pkg.sv - shared NoC VC defaults, flit/VC id types and credit width helper
package noc_vc_pkg;

    localparam int VC_DEFAULT         = 4;
    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef logic [DATA_WIDTH_DEFAULT-1:0]     flit_t;
    typedef logic [$clog2(VC_DEFAULT)-1:0]     vc_id_t;

    // Bits needed to hold a credit count ranging over 0..depth inclusive.
    function automatic int CW(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vc_plane_link_scheduler_if.sv
// rtl/vc_plane_link_scheduler_if.sv - per-VC flit inputs, credit returns and registered link output
interface vc_plane_link_scheduler_if
    import noc_vc_pkg::*;
#(
    parameter int VC         = VC_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int BUF_DEPTH  = 4
);
    localparam int CRED_W = CW(BUF_DEPTH);
    localparam int VC_W   = (VC > 1) ? $clog2(VC) : 1;

    logic [VC:0]               plane_sel;
    logic [VC*DATA_WIDTH-1:0]  in_data;
    logic [VC-1:0]             in_valid;
    logic [VC-1:0]             in_ready;
    logic [VC-1:0]             credit_in;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [VC_W-1:0]           out_vc;
    logic                      out_valid;
    logic [VC*CRED_W-1:0]      credits;
    logic [VC-1:0]             credit_err;

    modport master (
        output plane_sel, in_data, in_valid, credit_in,
        input  in_ready, out_data, out_vc, out_valid, credits, credit_err
    );

    modport slave (
        input  plane_sel, in_data, in_valid, credit_in,
        output in_ready, out_data, out_vc, out_valid, credits, credit_err
    );

endinterface

// File: rtl/vc_credit_counter.sv
// rtl/vc_credit_counter.sv - saturating downstream credit counter with sticky overflow flag
module vc_credit_counter
    import noc_vc_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    localparam int CRED_W   = CW(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              consume,
    input  logic              restore,
    output logic [CRED_W-1:0] count,
    output logic              err
);
    localparam logic [CRED_W-1:0] MAX_CREDIT = CRED_W'(BUF_DEPTH);

    logic [CRED_W-1:0] count_d, count_q;
    logic              err_d, err_q;

    // A consume and a restore in the same cycle cancel, so overflow is only
    // possible on a lone restore against a full counter.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case ({consume, restore})
            2'b10: count_d = count_q - 1'b1;
            2'b01: begin
                if (count_q == MAX_CREDIT) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= MAX_CREDIT;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign err   = err_q;

endmodule

// File: rtl/vc_plane_link_scheduler.sv
// rtl/vc_plane_link_scheduler.sv - plane-selected, credit-gated VC multiplexer onto one registered link
module vc_plane_link_scheduler
    import noc_vc_pkg::*;
#(
    parameter int VC         = VC_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int BUF_DEPTH  = 4
) (
    input logic                       clk,
    input logic                       rst,
    vc_plane_link_scheduler_if.slave  bus
);
    localparam int CRED_W = CW(BUF_DEPTH);
    localparam int VC_W   = (VC > 1) ? $clog2(VC) : 1;
    localparam int PS_W   = VC + 1;

    logic [CRED_W-1:0]    count [VC];
    logic [VC-1:0]        err;
    logic [VC-1:0]        ready;
    logic [VC-1:0]        fire;
    logic [VC*CRED_W-1:0] credits_flat;

    logic                  out_valid_d, out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
    logic [VC_W-1:0]       out_vc_d, out_vc_q;

    // The full plane_sel word is compared, so out-of-range planes match no VC.
    always_comb begin
        ready = '0;
        for (int v = 0; v < VC; v++) begin
            ready[v] = rst && (bus.plane_sel == PS_W'(v)) && (count[v] != '0);
        end
    end

    assign fire = bus.in_valid & ready;

    for (genvar g = 0; g < VC; g++) begin : g_credit
        vc_credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_counter (
            .clk     (clk),
            .rst     (rst),
            .consume (fire[g]),
            .restore (bus.credit_in[g]),
            .count   (count[g]),
            .err     (err[g])
        );
    end

    always_comb begin
        credits_flat = '0;
        for (int v = 0; v < VC; v++) begin
            credits_flat[v*CRED_W +: CRED_W] = count[v];
        end
    end

    // Link data and tag hold on idle cycles; only out_valid qualifies them.
    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_vc_d    = out_vc_q;
        for (int v = 0; v < VC; v++) begin
            if (fire[v]) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.in_data[v*DATA_WIDTH +: DATA_WIDTH];
                out_vc_d    = VC_W'(v);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_vc_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_vc_q    <= out_vc_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_vc     = out_vc_q;
    assign bus.credits    = credits_flat;
    assign bus.credit_err = err;

endmodule

// File: tb/tb_vc_plane_link_scheduler.sv
// tb/tb_vc_plane_link_scheduler.sv - directed self-checking bench for vc_plane_link_scheduler
module tb_vc_plane_link_scheduler;

    localparam int VC = 4;
    localparam int DW = 32;
    localparam int BD = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    vc_plane_link_scheduler_if #(.VC(VC), .DATA_WIDTH(DW), .BUF_DEPTH(BD)) bus ();

    vc_plane_link_scheduler #(.VC(VC), .DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.plane_sel = '0;
        bus.in_valid  = 4'hF;
        bus.credit_in = '0;
        bus.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        tick();
        tick();
        vectors++;
        if (bus.in_ready !== 4'h0) begin miscompares++; $display("FAIL reset_in_ready: got %0h expected 0", bus.in_ready); end
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0h expected 0", bus.out_valid); end
        vectors++;
        if (bus.out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
        vectors++;
        if (bus.out_vc !== 2'd0) begin miscompares++; $display("FAIL reset_out_vc: got %0h expected 0", bus.out_vc); end
        vectors++;
        if (bus.credits !== 12'h924) begin miscompares++; $display("FAIL reset_credits: got %0h expected 924", bus.credits); end
        vectors++;
        if (bus.credit_err !== 4'h0) begin miscompares++; $display("FAIL reset_credit_err: got %0h expected 0", bus.credit_err); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_ready;
        logic [31:0] exp_data;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.plane_sel = 5'(i % 4);
            exp_ready = 4'b0001 << (i % 4);
            exp_data  = 32'hA0 + 32'(i % 4);
            #1;
            vectors++;
            if (bus.in_ready !== exp_ready) begin miscompares++; $display("FAIL rr_in_ready[%0d]: got %0h expected %0h", i, bus.in_ready, exp_ready); end
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL rr_out_valid[%0d]: got %0h expected 1", i, bus.out_valid); end
            vectors++;
            if (bus.out_vc !== 2'(i % 4)) begin miscompares++; $display("FAIL rr_out_vc[%0d]: got %0h expected %0h", i, bus.out_vc, i % 4); end
            vectors++;
            if (bus.out_data !== exp_data) begin miscompares++; $display("FAIL rr_out_data[%0d]: got %0h expected %0h", i, bus.out_data, exp_data); end
        end
        bus.plane_sel = 5'd0;
        #1;
        vectors++;
        if (bus.in_ready !== 4'h0) begin miscompares++; $display("FAIL rr_drained_ready: got %0h expected 0", bus.in_ready); end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rr_drained_valid: got %0h expected 0", bus.out_valid); end
        vectors++;
        if (bus.credits !== 12'h000) begin miscompares++; $display("FAIL rr_drained_credits: got %0h expected 0", bus.credits); end
    endtask

    task automatic test_credit_return;
        bus.plane_sel = 5'd2;
        bus.credit_in = 4'b0100;
        #1;
        vectors++;
        if (bus.in_ready !== 4'h0) begin miscompares++; $display("FAIL cr_same_cycle_ready: got %0h expected 0", bus.in_ready); end
        tick();
        bus.credit_in = '0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL cr_no_fire: got %0h expected 0", bus.out_valid); end
        vectors++;
        if (bus.credits[8:6] !== 3'd1) begin miscompares++; $display("FAIL cr_credit_after_pulse: got %0h expected 1", bus.credits[8:6]); end
        for (int k = 1; k < 4; k++) begin
            bus.plane_sel = 5'((2 + k) % 4);
            tick();
            vectors++;
            if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL cr_idle[%0d]: got %0h expected 0", k, bus.out_valid); end
        end
        bus.plane_sel = 5'd2;
        bus.credit_in = 4'b0100;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0100) begin miscompares++; $display("FAIL cr_slot_ready: got %0h expected 4", bus.in_ready); end
        tick();
        bus.credit_in = '0;
        vectors++;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL cr_out_valid: got %0h expected 1", bus.out_valid); end
        vectors++;
        if (bus.out_vc !== 2'd2) begin miscompares++; $display("FAIL cr_out_vc: got %0h expected 2", bus.out_vc); end
        vectors++;
        if (bus.out_data !== 32'hA2) begin miscompares++; $display("FAIL cr_out_data: got %0h expected a2", bus.out_data); end
        vectors++;
        if (bus.credits[8:6] !== 3'd1) begin miscompares++; $display("FAIL cr_credit_after_fire: got %0h expected 1", bus.credits[8:6]); end
    endtask

    task automatic test_simultaneous;
        bus.plane_sel = 5'd3;
        bus.credit_in = 4'b0010;
        tick();
        bus.credit_in = '0;
        vectors++;
        if (bus.credits[5:3] !== 3'd1) begin miscompares++; $display("FAIL sim_preload: got %0h expected 1", bus.credits[5:3]); end
        bus.plane_sel = 5'd1;
        bus.credit_in = 4'b0010;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0010) begin miscompares++; $display("FAIL sim_ready: got %0h expected 2", bus.in_ready); end
        tick();
        bus.credit_in = '0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_vc !== 2'd1 || bus.out_data !== 32'hA1) begin
            miscompares++; $display("FAIL sim_link: got valid=%0h vc=%0h data=%0h expected 1/1/a1", bus.out_valid, bus.out_vc, bus.out_data);
        end
        vectors++;
        if (bus.credits[5:3] !== 3'd1) begin miscompares++; $display("FAIL sim_credit: got %0h expected 1", bus.credits[5:3]); end
        vectors++;
        if (bus.credit_err !== 4'h0) begin miscompares++; $display("FAIL sim_err: got %0h expected 0", bus.credit_err); end
    endtask

    task automatic test_overflow;
        bus.in_valid  = 4'b0111;
        bus.plane_sel = 5'd3;
        for (int k = 0; k < 4; k++) begin
            bus.credit_in = 4'b1000;
            tick();
        end
        bus.credit_in = '0;
        vectors++;
        if (bus.credits[11:9] !== 3'd4 || bus.credit_err !== 4'h0) begin
            miscompares++; $display("FAIL ovf_refill: got credit=%0h err=%0h expected 4/0", bus.credits[11:9], bus.credit_err);
        end
        bus.credit_in = 4'b1000;
        tick();
        bus.credit_in = '0;
        vectors++;
        if (bus.credits[11:9] !== 3'd4) begin miscompares++; $display("FAIL ovf_saturate: got %0h expected 4", bus.credits[11:9]); end
        vectors++;
        if (bus.credit_err !== 4'b1000) begin miscompares++; $display("FAIL ovf_err_set: got %0h expected 8", bus.credit_err); end
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if (bus.credit_err !== 4'b1000) begin miscompares++; $display("FAIL ovf_err_sticky[%0d]: got %0h expected 8", k, bus.credit_err); end
        end
    endtask

    task automatic test_bad_plane;
        bus.in_valid  = 4'hF;
        bus.plane_sel = 5'd5;
        for (int k = 0; k < 8; k++) begin
            #1;
            vectors++;
            if (bus.in_ready !== 4'h0) begin miscompares++; $display("FAIL bad_plane_ready[%0d]: got %0h expected 0", k, bus.in_ready); end
            tick();
            vectors++;
            if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bad_plane_valid[%0d]: got %0h expected 0", k, bus.out_valid); end
            vectors++;
            if (bus.credits !== 12'h848) begin miscompares++; $display("FAIL bad_plane_credits[%0d]: got %0h expected 848", k, bus.credits); end
        end
    endtask

    task automatic test_reset_mid;
        bus.plane_sel = 5'd5;
        bus.credit_in = 4'b0001;
        tick();
        tick();
        bus.credit_in = '0;
        bus.plane_sel = 5'd0;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA0) begin
            miscompares++; $display("FAIL rm_pre_valid: got valid=%0h data=%0h expected 1/a0", bus.out_valid, bus.out_data);
        end
        vectors++;
        if (bus.credits[2:0] !== 3'd1) begin miscompares++; $display("FAIL rm_pre_credit: got %0h expected 1", bus.credits[2:0]); end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 4'h0) begin miscompares++; $display("FAIL rm_ready_in_reset: got %0h expected 0", bus.in_ready); end
        tick();
        rst = 1'b1;
        bus.plane_sel = 5'd5;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_out_valid: got %0h expected 0", bus.out_valid); end
        vectors++;
        if (bus.out_data !== 32'h0 || bus.out_vc !== 2'd0) begin
            miscompares++; $display("FAIL rm_out_data: got data=%0h vc=%0h expected 0/0", bus.out_data, bus.out_vc);
        end
        vectors++;
        if (bus.credits !== 12'h924) begin miscompares++; $display("FAIL rm_credits: got %0h expected 924", bus.credits); end
        vectors++;
        if (bus.credit_err !== 4'h0) begin miscompares++; $display("FAIL rm_credit_err: got %0h expected 0", bus.credit_err); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b0;
        bus.plane_sel = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.credit_in = '0;
        test_reset();
        test_round_robin();
        test_credit_return();
        test_simultaneous();
        test_overflow();
        test_bad_plane();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
